reg_op_sequencer: RTL

- Micro-operation sequencer directly upstream of the 8x32 register file; sole driver of its wAddr, rAddr, wData, we, re and sole consumer of rData.
- Accepts one command at a time (op, dst, src_a, src_b, imm) over a valid/ready handshake.
- Reads operands through the single read port, computes a 32-bit result, writes it back to dst, then pulses done.

---
 rtl/reg_op_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: micro-operation sequencer that sits in front of an 8x32
// register file. It takes one command over valid/ready, reads operands
// through the single read port, computes a result, writes it back, and
// pulses done.
// Optional build macro: REG_SEQ_FLAGS_EN adds the flag_z/flag_c outputs.
//
// Handshake: a command transfers on a rising edge where cmd_valid=1 and
// cmd_ready=1. cmd_ready is high only in IDLE. The command fields are
// sampled on that edge only, so the producer may change them afterwards.
module reg_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [ADDR_W-1:0] rf_rAddr,
  output logic [DATA_W-1:0] rf_wData,
  output logic              rf_we,
  output logic              rf_re,
  input  logic [DATA_W-1:0] rf_rData,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        dbg_state
`ifdef REG_SEQ_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ_A = 2'd1,
    S_READ_B = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LI  = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W-1:0]   r_src_a;
  logic [ADDR_W-1:0]   r_src_b;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   w_alu;

  assign result    = r_result;
  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Command/operand latches and the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_ADD;
      r_dst    <= '0;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_imm    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_dst   <= cmd_dst;
            r_src_a <= cmd_src_a;
            r_src_b <= cmd_src_b;
            r_imm   <= cmd_imm;
          end
        end
        S_READ_A: r_op_a <= rf_rData;
        S_READ_B: r_op_b <= rf_rData;
        S_WRITE:  if (r_op != OP_NOP) r_result <= w_alu;
        default: ;
      endcase
    end
  end

  // Result datapath; arithmetic wraps modulo 2^DATA_W.
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD: w_alu = r_op_a + r_op_b;
      OP_SUB: w_alu = r_op_a - r_op_b;
      OP_AND: w_alu = r_op_a & r_op_b;
      OP_OR:  w_alu = r_op_a | r_op_b;
      OP_XOR: w_alu = r_op_a ^ r_op_b;
      OP_LI:  w_alu = r_imm;
      OP_MOV: w_alu = r_op_a;
      default: w_alu = '0;
    endcase
  end

  // Next-state and register-file port control. Write enable and done are
  // gated by reset so an aborted command never commits or retires.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rf_re     = 1'b0;
    rf_we     = 1'b0;
    rf_rAddr  = '0;
    rf_wAddr  = '0;
    rf_wData  = '0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_LI || cmd_op == OP_NOP) w_next = S_WRITE;
          else                                     w_next = S_READ_A;
        end
      end
      S_READ_A: begin
        rf_re    = 1'b1;
        rf_rAddr = r_src_a;
        w_next   = (r_op == OP_MOV) ? S_WRITE : S_READ_B;
      end
      S_READ_B: begin
        rf_re    = 1'b1;
        rf_rAddr = r_src_b;
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        rf_wAddr = r_dst;
        rf_wData = w_alu;
        rf_we    = (r_op != OP_NOP) && !reset;
        done     = !reset;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef REG_SEQ_FLAGS_EN
  // Status flags, updated only when a non-NOP command retires. A sum that
  // wraps below operand A means the add carried out.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (r_state == S_WRITE && r_op != OP_NOP) begin
      flag_z <= (w_alu == '0);
      case (r_op)
        OP_ADD:  flag_c <= (w_alu < r_op_a);
        OP_SUB:  flag_c <= (r_op_a < r_op_b);
        default: flag_c <= 1'b0;
      endcase
    end
  end
`endif

endmodule
